// File: rtl/access_pkg.sv
// Shared types and constants for the keypad access session controller.
// Pure declarations: no timing or flow-control behaviour of its own.
package access_pkg;

  localparam int DIGITS  = 4;
  localparam int DIGIT_W = 4;
  localparam int CODE_W  = 16;
  localparam int CNT_W   = 2;

  typedef enum logic [2:0] {
    ST_ID_ENTRY   = 3'd0,
    ST_LOOKUP     = 3'd1,
    ST_PASS_ENTRY = 3'd2,
    ST_CHECK      = 3'd3,
    ST_GRANT      = 3'd4,
    ST_LOCKOUT    = 3'd5
  } state_e;

  // Digit index 0 is the first key pressed, held in the top nibble.
  function automatic logic [DIGIT_W-1:0] code_nibble(input logic [CODE_W-1:0] code,
                                                     input logic [CNT_W-1:0]  idx);
    return code[(DIGITS - 1 - int'(idx)) * DIGIT_W +: DIGIT_W];
  endfunction

endpackage

// File: rtl/access_timer.sv
// Shared 32-bit loadable down-counter; expired is high while the count sits at zero.
// One-cycle load latency, no backpressure: load wins over counting every cycle.
module access_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] value,
  output logic        expired
);

  logic [31:0] count_q;
  logic [31:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = value;
    end else if (count_q != 32'd0) begin
      count_d = count_q - 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == 32'd0);

endmodule

// File: rtl/access_session_ctrl.sv
// Keypad session FSM: ID entry, user-store lookup, password check, grant/lockout timing.
// All outputs registered (one cycle after the deciding edge); lookup waits indefinitely for ack.
module access_session_ctrl
  import access_pkg::*;
#(
  parameter int unsigned MAX_ATTEMPTS   = 3,
  parameter int unsigned UNLOCK_CYCLES  = 50_000_000,
  parameter int unsigned LOCKOUT_CYCLES = 500_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 250_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                loadButton_s,
  input  logic [DIGIT_W-1:0]  passInput,
  output logic                lookupReq,
  output logic [CODE_W-1:0]   lookupID,
  input  logic                lookupAck,
  input  logic                lookupHit,
  input  logic [CODE_W-1:0]   lookupPass,
  output logic                unlock,
  output logic                lockedOut,
  output logic                errorPulse,
  output logic [1:0]          attemptsUsed,
  output logic [2:0]          stateCode
);

  // Timer is loaded with N-1 so that a state held until expiry lasts exactly N cycles.
  localparam logic [31:0] UNLOCK_LOAD  = 32'(UNLOCK_CYCLES - 1);
  localparam logic [31:0] LOCKOUT_LOAD = 32'(LOCKOUT_CYCLES - 1);
  localparam logic [31:0] TIMEOUT_LOAD = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]  MAX_ATT      = 2'(MAX_ATTEMPTS);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CODE_W-1:0]   id_q, id_d;
  logic [CODE_W-1:0]   pass_q, pass_d;
  logic                mismatch_q, mismatch_d;
  logic [1:0]          attempts_q, attempts_d;
  logic                lookup_req_q, lookup_req_d;
  logic                unlock_q, unlock_d;
  logic                locked_out_q, locked_out_d;
  logic                error_pulse_q, error_pulse_d;

  logic                tmr_load;
  logic [31:0]         tmr_value;
  logic                tmr_expired;
  logic [1:0]          attempts_inc;

  assign attempts_inc = attempts_q + 2'd1;

  access_timer u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load),
    .value   (tmr_value),
    .expired (tmr_expired)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    id_d          = id_q;
    pass_d        = pass_q;
    mismatch_d    = mismatch_q;
    attempts_d    = attempts_q;
    error_pulse_d = 1'b0;
    tmr_load      = 1'b0;
    tmr_value     = TIMEOUT_LOAD;

    unique case (state_q)
      ST_ID_ENTRY: begin
        if (loadButton_s) begin
          id_d     = {id_q[CODE_W-DIGIT_W-1:0], passInput};
          tmr_load = 1'b1;
          if (cnt_q == CNT_W'(DIGITS - 1)) begin
            cnt_d   = '0;
            state_d = ST_LOOKUP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (cnt_q != '0 && tmr_expired) begin
          error_pulse_d = 1'b1;
          cnt_d         = '0;
          id_d          = '0;
          mismatch_d    = 1'b0;
        end
      end

      ST_LOOKUP: begin
        if (lookupAck) begin
          if (lookupHit) begin
            pass_d     = lookupPass;
            cnt_d      = '0;
            mismatch_d = 1'b0;
            tmr_load   = 1'b1;
            state_d    = ST_PASS_ENTRY;
          end else begin
            error_pulse_d = 1'b1;
            state_d       = ST_ID_ENTRY;
          end
        end
      end

      ST_PASS_ENTRY: begin
        if (loadButton_s) begin
          if (passInput != code_nibble(pass_q, cnt_q)) begin
            mismatch_d = 1'b1;
          end
          tmr_load = 1'b1;
          if (cnt_q == CNT_W'(DIGITS - 1)) begin
            cnt_d   = '0;
            state_d = ST_CHECK;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (tmr_expired) begin
          // Attempt count deliberately survives a timeout.
          error_pulse_d = 1'b1;
          cnt_d         = '0;
          id_d          = '0;
          mismatch_d    = 1'b0;
          state_d       = ST_ID_ENTRY;
        end
      end

      ST_CHECK: begin
        tmr_load = 1'b1;
        if (!mismatch_q) begin
          attempts_d = '0;
          tmr_value  = UNLOCK_LOAD;
          state_d    = ST_GRANT;
        end else begin
          error_pulse_d = 1'b1;
          attempts_d    = attempts_inc;
          if (attempts_inc == MAX_ATT) begin
            tmr_value = LOCKOUT_LOAD;
            state_d   = ST_LOCKOUT;
          end else begin
            cnt_d      = '0;
            mismatch_d = 1'b0;
            state_d    = ST_PASS_ENTRY;
          end
        end
      end

      ST_GRANT: begin
        if (tmr_expired) begin
          state_d = ST_ID_ENTRY;
        end
      end

      ST_LOCKOUT: begin
        if (tmr_expired) begin
          attempts_d = '0;
          state_d    = ST_ID_ENTRY;
        end
      end

      default: begin
        state_d = ST_ID_ENTRY;
      end
    endcase

    lookup_req_d = (state_d == ST_LOOKUP);
    unlock_d     = (state_d == ST_GRANT);
    locked_out_d = (state_d == ST_LOCKOUT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_ID_ENTRY;
      cnt_q         <= '0;
      id_q          <= '0;
      pass_q        <= '0;
      mismatch_q    <= 1'b0;
      attempts_q    <= '0;
      lookup_req_q  <= 1'b0;
      unlock_q      <= 1'b0;
      locked_out_q  <= 1'b0;
      error_pulse_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      id_q          <= id_d;
      pass_q        <= pass_d;
      mismatch_q    <= mismatch_d;
      attempts_q    <= attempts_d;
      lookup_req_q  <= lookup_req_d;
      unlock_q      <= unlock_d;
      locked_out_q  <= locked_out_d;
      error_pulse_q <= error_pulse_d;
    end
  end

  assign lookupReq    = lookup_req_q;
  assign lookupID     = id_q;
  assign unlock       = unlock_q;
  assign lockedOut    = locked_out_q;
  assign errorPulse   = error_pulse_q;
  assign attemptsUsed = attempts_q;
  assign stateCode    = state_q;

endmodule

// File: tb/tb_access_session_ctrl.sv
// Scoreboard bench for access_session_ctrl: expected output events are queued by the
// stimulus and popped by a negedge monitor as the DUT produces them.
module tb_access_session_ctrl;

  localparam int UNL = 8;
  localparam int LCK = 12;
  localparam int TMO = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        loadButton_s = 1'b0;
  logic [3:0]  passInput = 4'h0;
  logic        lookupReq;
  logic [15:0] lookupID;
  logic        lookupAck = 1'b0;
  logic        lookupHit = 1'b0;
  logic [15:0] lookupPass = 16'h0;
  logic        unlock;
  logic        lockedOut;
  logic        errorPulse;
  logic [1:0]  attemptsUsed;
  logic [2:0]  stateCode;

  access_session_ctrl #(
    .MAX_ATTEMPTS   (3),
    .UNLOCK_CYCLES  (UNL),
    .LOCKOUT_CYCLES (LCK),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .loadButton_s (loadButton_s),
    .passInput    (passInput),
    .lookupReq    (lookupReq),
    .lookupID     (lookupID),
    .lookupAck    (lookupAck),
    .lookupHit    (lookupHit),
    .lookupPass   (lookupPass),
    .unlock       (unlock),
    .lockedOut    (lockedOut),
    .errorPulse   (errorPulse),
    .attemptsUsed (attemptsUsed),
    .stateCode    (stateCode)
  );

  always #5 clk = ~clk;

  // REQ: lookupID at request rise. ERR: {stateCode, attemptsUsed} during the pulse.
  // UNL/LCK: {stateCode, attemptsUsed, high-cycle count} sampled the cycle the output drops.
  typedef enum int {EV_REQ = 0, EV_ERR = 1, EV_UNL = 2, EV_LCK = 3} ev_e;
  typedef struct {
    ev_e         kind;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic string ev_name(input ev_e k);
    case (k)
      EV_REQ:  return "req";
      EV_ERR:  return "err";
      EV_UNL:  return "unlock";
      default: return "lockout";
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input ev_e k, input logic [31:0] d);
    exp_t e;
    e.kind = k;
    e.data = d;
    exp_q.push_back(e);
  endtask

  function automatic logic [31:0] err_data(input logic [2:0] st, input logic [1:0] att);
    return {27'd0, st, att};
  endfunction

  function automatic logic [31:0] win_data(input logic [2:0] st, input logic [1:0] att,
                                           input int len);
    return {11'd0, st, att, 16'(len)};
  endfunction

  task automatic emit(input ev_e k, input logic [31:0] d);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_%s actual=%0h expected=none", ev_name(k), d);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", 32'(k), 32'(e.kind));
      check({"event_", ev_name(e.kind)}, d, e.data);
    end
  endtask

  initial begin : monitor
    int   ul;
    int   ll;
    logic rp;
    ul = 0;
    ll = 0;
    rp = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ul = 0;
        ll = 0;
        rp = 1'b0;
      end else begin
        if (lookupReq && !rp) emit(EV_REQ, {16'd0, lookupID});
        if (errorPulse) emit(EV_ERR, err_data(stateCode, attemptsUsed));
        if (unlock) begin
          ul++;
        end else if (ul != 0) begin
          emit(EV_UNL, win_data(stateCode, attemptsUsed, ul));
          ul = 0;
        end
        if (lockedOut) begin
          ll++;
        end else if (ll != 0) begin
          emit(EV_LCK, win_data(stateCode, attemptsUsed, ll));
          ll = 0;
        end
        rp = lookupReq;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic press(input logic [3:0] d);
    loadButton_s = 1'b1;
    passInput    = d;
    step();
    loadButton_s = 1'b0;
  endtask

  task automatic enter4(input logic [15:0] c);
    for (int i = 3; i >= 0; i--) press(c[i*4 +: 4]);
  endtask

  task automatic ack(input logic hit, input logic [15:0] pass);
    int n;
    n = 0;
    while (!lookupReq && n < 50) begin
      step();
      n++;
    end
    check("lookup_req_seen", 32'(lookupReq), 32'd1);
    lookupAck  = 1'b1;
    lookupHit  = hit;
    lookupPass = pass;
    step();
    lookupAck  = 1'b0;
    lookupHit  = 1'b0;
    lookupPass = 16'h0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_state"},    32'(stateCode),    32'd0);
    check({tag, "_req"},      32'(lookupReq),    32'd0);
    check({tag, "_id"},       32'(lookupID),     32'd0);
    check({tag, "_unlock"},   32'(unlock),       32'd0);
    check({tag, "_locked"},   32'(lockedOut),    32'd0);
    check({tag, "_err"},      32'(errorPulse),   32'd0);
    check({tag, "_attempts"}, 32'(attemptsUsed), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(3);
    check_reset("reset");
    rst = 1'b0;
    step();

    // Successful session: unlock held UNL cycles, attempts cleared.
    expect_ev(EV_REQ, 32'h1234);
    expect_ev(EV_UNL, win_data(3'd0, 2'd0, UNL));
    enter4(16'h1234);
    ack(1'b1, 16'hBEEF);
    enter4(16'hBEEF);
    check("check_state", 32'(stateCode), 32'd3);
    step();
    check("grant_unlock", 32'(unlock), 32'd1);
    check("grant_attempts", 32'(attemptsUsed), 32'd0);
    idle(UNL + 4);

    // Lookup miss: error, back to ID entry, no attempt charged.
    expect_ev(EV_REQ, 32'h1234);
    expect_ev(EV_ERR, err_data(3'd0, 2'd0));
    enter4(16'h1234);
    ack(1'b0, 16'h0);
    idle(2);

    // Three wrong passwords lead to lockout; strobes during lockout are ignored.
    expect_ev(EV_REQ, 32'h1234);
    enter4(16'h1234);
    ack(1'b1, 16'hBEEF);
    expect_ev(EV_ERR, err_data(3'd2, 2'd1));
    enter4(16'hBEEE);
    step();
    expect_ev(EV_ERR, err_data(3'd2, 2'd2));
    enter4(16'hBEEE);
    step();
    expect_ev(EV_ERR, err_data(3'd5, 2'd3));
    expect_ev(EV_LCK, win_data(3'd0, 2'd0, LCK));
    enter4(16'hBEEE);
    step();
    enter4(16'h1111);
    check("lockout_state", 32'(stateCode), 32'd5);
    check("lockout_active", 32'(lockedOut), 32'd1);
    idle(LCK + 2);
    check("after_lockout_attempts", 32'(attemptsUsed), 32'd0);

    // Timeout after one failure keeps the attempt count.
    expect_ev(EV_REQ, 32'h1234);
    enter4(16'h1234);
    ack(1'b1, 16'hBEEF);
    expect_ev(EV_ERR, err_data(3'd2, 2'd1));
    enter4(16'hBEEE);
    step();
    press(4'hB);
    press(4'hE);
    expect_ev(EV_ERR, err_data(3'd0, 2'd1));
    idle(TMO + 3);
    check("timeout_state", 32'(stateCode), 32'd0);
    check("timeout_attempts", 32'(attemptsUsed), 32'd1);

    // Strobe landing on the expiry edge is accepted; lookup holds while ack is low.
    expect_ev(EV_REQ, 32'h5678);
    press(4'h5);
    idle(TMO - 1);
    press(4'h6);
    press(4'h7);
    press(4'h8);
    for (int i = 0; i < 20; i++) begin
      check("hold_req", 32'(lookupReq), 32'd1);
      check("hold_id", 32'(lookupID), 32'h5678);
      step();
    end
    expect_ev(EV_ERR, err_data(3'd0, 2'd1));
    ack(1'b0, 16'h0);
    idle(2);

    // Reset in the middle of a grant aborts cleanly.
    expect_ev(EV_REQ, 32'h1234);
    enter4(16'h1234);
    ack(1'b1, 16'hBEEF);
    enter4(16'hBEEF);
    idle(3);
    check("pre_abort_unlock", 32'(unlock), 32'd1);
    rst = 1'b1;
    step();
    check_reset("abort");
    rst = 1'b0;
    idle(5);

    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    while (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      $display("FAIL missing_%s actual=none expected=%0h", ev_name(e.kind), e.data);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/access_session_ctrl.md
# access_session_ctrl

Session controller that sequences a complete keypad access transaction. It collects a 4-nibble user ID, looks it up in the user store over a req/ack handshake, and collects and checks a 4-nibble password. It also counts failed attempts, enforces a timed lockout, and drives a timed unlock. It sits between the debounced keypad front end (`loadButton_s`, `passInput`) and the door/LED outputs, replacing ad-hoc per-block attempt counting with one authoritative session FSM.

## Interface
Parameters:
- `MAX_ATTEMPTS`, default 3: failed password checks (1..3) before lockout.
- `UNLOCK_CYCLES`, default 50_000_000: cycles `unlock` is held high.
- `LOCKOUT_CYCLES`, default 500_000_000: cycles `lockedOut` is held high.
- `TIMEOUT_CYCLES`, default 250_000_000: idle cycles allowed between digit presses.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `loadButton_s` in 1: debounced one-cycle digit strobe.
- `passInput` in 4: digit value, valid when `loadButton_s`=1.
- `lookupReq` out 1: user-store request.
- `lookupID` out 16: collected ID, first digit in [15:12].
- `lookupAck` in 1: one-cycle response strobe.
- `lookupHit` in 1: ID exists, valid with ack.
- `lookupPass` in 16: stored password, valid with ack.
- `unlock` out 1: door release.
- `lockedOut` out 1: lockout active.
- `errorPulse` out 1: one-cycle strobe on lookup miss, wrong password, or timeout.
- `attemptsUsed` out 2: failed checks since last clear.
- `stateCode` out 3: current FSM state, for display.

## Operation
FSM states and their encodings:
- `ID_ENTRY` (0): each strobe shifts `passInput` into the ID register, MSB nibble first. The digit counter runs 0→3; the 4th strobe moves the FSM to `LOOKUP`.
- `LOOKUP` (1): `lookupReq`=1 with `lookupID` stable until the cycle `lookupAck`=1 is sampled. On ack with hit: latch `lookupPass`, go to `PASS_ENTRY`. On ack with miss: `errorPulse`, go to `ID_ENTRY`. A miss does not count as an attempt.
- `PASS_ENTRY` (2): each strobe compares the digit against the matching latched nibble. Any mismatch sets the sticky `mismatch` flag. The 4th strobe moves the FSM to `CHECK`.
- `CHECK` (3): one cycle.
  - `mismatch`=0 → `GRANT`, `attemptsUsed`←0.
  - `mismatch`=1 → `errorPulse`, `attemptsUsed`+1. The FSM goes to `LOCKOUT` if the new count equals `MAX_ATTEMPTS`, otherwise back to `PASS_ENTRY` for the same user with the digit count and `mismatch` cleared.
- `GRANT` (4): `unlock`=1 for exactly `UNLOCK_CYCLES`, then `ID_ENTRY`.
- `LOCKOUT` (5): `lockedOut`=1 for exactly `LOCKOUT_CYCLES`, then `ID_ENTRY` with `attemptsUsed`←0.

Strobes are ignored in `LOOKUP`, `CHECK`, `GRANT` and `LOCKOUT`, and they do not restart any timer in those states.

Entry timeout:
- The timer is armed in `ID_ENTRY` when at least 1 digit has been entered, and always in `PASS_ENTRY`.
- Each strobe reloads the timer.
- On expiry: `errorPulse`, go to `ID_ENTRY`, clear the digit count, ID and `mismatch`.
- `attemptsUsed` is preserved across a timeout, so the lockout count cannot be evaded by timing out.
- If a strobe and expiry occur in the same cycle, the strobe wins: the digit is accepted and the timer reloads.

`attemptsUsed` is cleared only by `rst`, a successful `CHECK`, or the end of `LOCKOUT`.

## Timing
- Reset values: state `ID_ENTRY`, all counters 0; `lookupReq`=0, `lookupID`=0, `unlock`=0, `lockedOut`=0, `errorPulse`=0, `attemptsUsed`=0, `stateCode`=0.
- All outputs are registered.
- 4th ID strobe sampled at edge k → `lookupReq`=1 after edge k.
- Ack sampled at edge m → `lookupReq`=0 after edge m.
- `lookupAck` arriving while not in `LOOKUP` is ignored.
- 4th password strobe at edge k → `CHECK` after k. After edge k+1, `unlock`=1 or `errorPulse`=1 (exactly one cycle).
- `unlock` and `lockedOut` are high for exactly their parameter count of cycles, then low on the same edge that the state becomes `ID_ENTRY`.
- `rst` asserted mid-session aborts immediately on the next edge; no output pulses result from the abort.
- There is no ack timeout on `LOOKUP`. The user store must answer.

## Structure
- Package `access_pkg`: state enum (3-bit encodings above), `DIGITS`=4, `DIGIT_W`=4, `CODE_W`=16.
- Sub-module `access_timer`: a single 32-bit loadable down-counter with a `load`/`value`/`expired` interface. One instance is shared, reloaded on state entry for grant, lockout and timeout, and on each accepted strobe.

## Test plan
- ID 0x1234, ack hit with pass 0xBEEF, enter B,E,E,F → `unlock`=1 one cycle after `CHECK`, held `UNLOCK_CYCLES` (set to 8 in the bench), `attemptsUsed`=0.
- ID 0x1234, ack miss → `errorPulse` one cycle, `stateCode`=0, `attemptsUsed` unchanged.
- With `MAX_ATTEMPTS`=3, enter a wrong password (0xBEEE) 3 times:
  - `attemptsUsed` goes 1, 2, 3.
  - The third failure sets `lockedOut`=1 for `LOCKOUT_CYCLES`; strobes during lockout are ignored.
  - `attemptsUsed`=0 afterwards.
- One wrong password, then 2 digits, then idle for `TIMEOUT_CYCLES` → `errorPulse`, `ID_ENTRY`, `attemptsUsed` stays 1.
- Strobe on the exact expiry cycle → digit accepted, no `errorPulse`. Hold ack low 20 cycles → `lookupReq` and `lookupID` remain stable.
- Assert `rst` for 1 cycle during `GRANT` → `unlock`=0 and all reset values on the next edge.
